// File: rtl/sdram_wb_bridge.sv
// Wishbone 32-bit slave to 16-bit SDRAM controller port, with a one-line read buffer.
// Writes split into halfwords; read misses fill the line, and hits complete locally.
module sdram_wb_bridge #(
  parameter int unsigned BURST_LENGTH = 8,
  parameter int unsigned LB           = 3
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [31:0] ctrl_adr_o,
  output logic [15:0] ctrl_dat_o,
  output logic [1:0]  ctrl_sel_o,
  output logic        ctrl_we_o,
  output logic        ctrl_acc_o,
  input  logic        ctrl_ack_i,
  input  logic [31:0] ctrl_adr_i,
  input  logic [15:0] ctrl_dat_i
);

  localparam int unsigned TAG_W = 31 - LB;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_HI, S_WR_LO, S_RD_REQ, S_RD_FILL, S_ACK
  } state_e;

  state_e           state_q, state_d, req_st;
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [LB-1:0]    cnt_q, cnt_d;
  logic             wb_ack_q;
  logic [31:0]      wb_dat_q, wb_dat_d;
  logic [15:0]      line_q [BURST_LENGTH];

  logic             req;
  logic             hit;
  logic [LB-1:0]    idx_hi, idx_lo;
  logic             unused_bits;

  assign req         = wb_cyc_i & wb_stb_i;
  assign hit         = valid_q && (tag_q == wb_adr_i[31:LB+1]);
  assign idx_hi      = wb_adr_i[LB:1] & ~LB'(1);
  assign idx_lo      = idx_hi | LB'(1);
  assign unused_bits = ^{wb_adr_i[0], ctrl_adr_i[31:LB+1], ctrl_adr_i[0]};

  // Next-state and buffer bookkeeping
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    wb_dat_d = wb_dat_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (wb_we_i) begin
            if (wb_sel_i[3:2] != 2'b00)      state_d = S_WR_HI;
            else if (wb_sel_i[1:0] != 2'b00) state_d = S_WR_LO;
            else                             state_d = S_ACK;
          end else if (hit) begin
            state_d  = S_ACK;
            wb_dat_d = {line_q[idx_hi], line_q[idx_lo]};
          end else begin
            state_d = S_RD_REQ;
            valid_d = 1'b0;
          end
        end
      end
      S_WR_HI: begin
        if (ctrl_ack_i) begin
          if (wb_sel_i[1:0] != 2'b00) state_d = S_WR_LO;
          else                        state_d = wb_cyc_i ? S_ACK : S_IDLE;
        end
      end
      S_WR_LO: begin
        if (ctrl_ack_i) state_d = wb_cyc_i ? S_ACK : S_IDLE;
      end
      S_RD_REQ: begin
        if (ctrl_ack_i) begin
          cnt_d   = LB'(1);
          state_d = S_RD_FILL;
        end
      end
      S_RD_FILL: begin
        cnt_d = cnt_q + LB'(1);
        if (cnt_q == LB'(BURST_LENGTH - 1)) begin
          tag_d   = wb_adr_i[31:LB+1];
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller request: in an ack cycle the following request is already shown
  always_comb begin
    req_st     = state_q;
    ctrl_acc_o = 1'b0;
    ctrl_we_o  = 1'b0;
    ctrl_adr_o = 32'h0;
    ctrl_dat_o = 16'h0;
    ctrl_sel_o = 2'b00;
    if (ctrl_ack_i && (state_q inside {S_WR_HI, S_WR_LO, S_RD_REQ})) req_st = state_d;
    case (req_st)
      S_WR_HI: begin
        ctrl_acc_o = 1'b1;
        ctrl_we_o  = 1'b1;
        ctrl_adr_o = {wb_adr_i[31:2], 2'b00};
        ctrl_dat_o = wb_dat_i[31:16];
        ctrl_sel_o = wb_sel_i[3:2];
      end
      S_WR_LO: begin
        ctrl_acc_o = 1'b1;
        ctrl_we_o  = 1'b1;
        ctrl_adr_o = {wb_adr_i[31:2], 2'b10};
        ctrl_dat_o = wb_dat_i[15:0];
        ctrl_sel_o = wb_sel_i[1:0];
      end
      S_RD_REQ: begin
        ctrl_acc_o = 1'b1;
        ctrl_adr_o = {wb_adr_i[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      cnt_q    <= '0;
      wb_ack_q <= 1'b0;
      wb_dat_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      wb_ack_q <= (state_d == S_ACK);
      wb_dat_q <= wb_dat_d;
    end
  end

  // Line storage: burst fill, plus write-through of accepted halfwords on a hit
  always_ff @(posedge sdram_clk) begin
    if ((state_q == S_RD_REQ && ctrl_ack_i) || state_q == S_RD_FILL) begin
      line_q[ctrl_adr_i[LB:1]] <= ctrl_dat_i;
    end else if (ctrl_ack_i && hit && state_q == S_WR_HI) begin
      if (wb_sel_i[3]) line_q[idx_hi][15:8] <= wb_dat_i[31:24];
      if (wb_sel_i[2]) line_q[idx_hi][7:0]  <= wb_dat_i[23:16];
    end else if (ctrl_ack_i && hit && state_q == S_WR_LO) begin
      if (wb_sel_i[1]) line_q[idx_lo][15:8] <= wb_dat_i[15:8];
      if (wb_sel_i[0]) line_q[idx_lo][7:0]  <= wb_dat_i[7:0];
    end
  end

  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench for sdram_wb_bridge; the bench plays the SDRAM controller by hand.
module tb_sdram_wb_bridge;

  logic        clk, rst_n;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;
  logic [31:0] c_adr_o, c_adr_i;
  logic [15:0] c_dat_o, c_dat_i;
  logic [1:0]  c_sel;
  logic        c_we, c_acc, c_ack;

  int n_checks = 0;
  int n_errors = 0;

  int          n_wr = 0, n_rd = 0, n_ack = 0;
  logic [31:0] wr_adr [16];
  logic [15:0] wr_dat [16];
  logic [1:0]  wr_sel [16];
  logic        prev_acc = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = 32'h0;

  int w0, r0, a0;

  sdram_wb_bridge #(.BURST_LENGTH(8), .LB(3)) dut (
    .sdram_clk   (clk),
    .sdram_rst_n (rst_n),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat_w),
    .wb_sel_i    (wb_sel),
    .wb_we_i     (wb_we),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_dat_o    (wb_dat_r),
    .wb_ack_o    (wb_ack),
    .ctrl_adr_o  (c_adr_o),
    .ctrl_dat_o  (c_dat_o),
    .ctrl_sel_o  (c_sel),
    .ctrl_we_o   (c_we),
    .ctrl_acc_o  (c_acc),
    .ctrl_ack_i  (c_ack),
    .ctrl_adr_i  (c_adr_i),
    .ctrl_dat_i  (c_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log each distinct controller request and every wishbone ack
  always @(posedge clk) begin
    if (c_acc && (!prev_acc || c_adr_o != prev_adr || c_we != prev_we)) begin
      if (c_we) begin
        wr_adr[n_wr % 16] = c_adr_o;
        wr_dat[n_wr % 16] = c_dat_o;
        wr_sel[n_wr % 16] = c_sel;
        n_wr++;
      end else begin
        n_rd++;
      end
    end
    prev_acc = c_acc;
    prev_adr = c_adr_o;
    prev_we  = c_we;
    if (wb_ack) n_ack++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic we);
    wb_adr = a; wb_dat_w = d; wb_sel = s; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask

  task automatic wb_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [15:0] d, input logic ack);
    c_adr_i = a; c_dat_i = d; c_ack = ack;
  endtask

  initial begin
    rst_n = 1'b0; wb_adr = 32'h0; wb_dat_w = 32'h0; wb_sel = 4'h0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; c_ack = 1'b0; c_adr_i = 32'h0; c_dat_i = 16'h0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ack", 32'(wb_ack), 32'h0);
    check("rst_dat", wb_dat_r, 32'h0);
    check("rst_acc", 32'(c_acc), 32'h0);
    check("rst_adr", c_adr_o, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Full 32-bit write split into two halfwords
    @(negedge clk); wb_drive(32'h100, 32'h11223344, 4'hF, 1'b1);
    w0 = n_wr; a0 = n_ack;
    #1 check("wr_idle_acc", 32'(c_acc), 32'h0);
    @(negedge clk); #1;
    check("wr_hi_acc", 32'(c_acc), 32'h1);
    check("wr_hi_we", 32'(c_we), 32'h1);
    check("wr_hi_adr", c_adr_o, 32'h100);
    check("wr_hi_dat", 32'(c_dat_o), 32'h1122);
    check("wr_hi_sel", 32'(c_sel), 32'h3);
    @(negedge clk); c_ack = 1'b1;
    #1 check("wr_ackcyc_adr", c_adr_o, 32'h102);
    check("wr_ackcyc_dat", 32'(c_dat_o), 32'h3344);
    check("wr_ackcyc_acc", 32'(c_acc), 32'h1);
    @(negedge clk); #1 check("wr_lo_ack_acc", 32'(c_acc), 32'h0);
    @(negedge clk); c_ack = 1'b0;
    #1 check("wr_wback", 32'(wb_ack), 32'h1);
    wb_idle();
    check("wr_count", 32'(n_wr - w0), 32'h2);
    check("wr0_adr", wr_adr[w0 % 16], 32'h100);
    check("wr0_dat", 32'(wr_dat[w0 % 16]), 32'h1122);
    check("wr1_adr", wr_adr[(w0 + 1) % 16], 32'h102);
    check("wr1_dat", 32'(wr_dat[(w0 + 1) % 16]), 32'h3344);
    check("wr1_sel", 32'(wr_sel[(w0 + 1) % 16]), 32'h3);
    @(negedge clk); #1 check("wr_single_ack", 32'(wb_ack), 32'h0);
    check("wr_ack_count", 32'(n_ack - a0), 32'h1);

    // Low-halfword-only write
    @(negedge clk); wb_drive(32'h200, 32'hDEADBEEF, 4'h3, 1'b1); w0 = n_wr;
    @(negedge clk); #1;
    check("wl_acc", 32'(c_acc), 32'h1);
    check("wl_adr", c_adr_o, 32'h202);
    check("wl_dat", 32'(c_dat_o), 32'hBEEF);
    check("wl_sel", 32'(c_sel), 32'h3);
    @(negedge clk); c_ack = 1'b1;
    #1 check("wl_ackcyc_acc", 32'(c_acc), 32'h0);
    @(negedge clk); c_ack = 1'b0;
    #1 check("wl_wback", 32'(wb_ack), 32'h1);
    wb_idle();
    check("wl_count", 32'(n_wr - w0), 32'h1);

    // Write with no byte lanes: ack at N+1 and no controller traffic
    @(negedge clk); wb_drive(32'h204, 32'h55555555, 4'h0, 1'b1); w0 = n_wr;
    #1 check("w0_acc", 32'(c_acc), 32'h0);
    @(negedge clk); #1 check("w0_wback", 32'(wb_ack), 32'h1);
    check("w0_acc2", 32'(c_acc), 32'h0);
    wb_idle();
    @(negedge clk); #1 check("w0_count", 32'(n_wr - w0), 32'h0);

    // Read miss at 0x104, controller returns critical word first and wraps
    @(negedge clk); wb_drive(32'h104, 32'h0, 4'hF, 1'b0); r0 = n_rd; a0 = n_ack;
    @(negedge clk); #1;
    check("rm_acc", 32'(c_acc), 32'h1);
    check("rm_we", 32'(c_we), 32'h0);
    check("rm_adr", c_adr_o, 32'h104);
    @(negedge clk); beat(32'h104, 16'hC0D2, 1'b1);
    #1 check("rm_ackcyc_acc", 32'(c_acc), 32'h0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      beat(32'h100 | 32'((4 + 2 * k) & 14), 16'hC0D0 + 16'((2 + k) & 7), 1'b0);
      #1 check("rm_fill_acc", 32'(c_acc), 32'h0);
    end
    @(negedge clk); #1 check("rm_early_ack", 32'(wb_ack), 32'h0);
    @(negedge clk); #1 check("rm_wback", 32'(wb_ack), 32'h1);
    check("rm_dat", wb_dat_r, 32'hC0D2C0D3);
    wb_idle();
    check("rm_rd_count", 32'(n_rd - r0), 32'h1);

    // Hit, write-through to the high halfword, then re-read
    @(negedge clk); wb_drive(32'h10C, 32'h0, 4'hF, 1'b0); r0 = n_rd;
    #1 check("rh_n0", 32'(wb_ack), 32'h0);
    @(negedge clk); #1 check("rh_wback", 32'(wb_ack), 32'h1);
    check("rh_dat", wb_dat_r, 32'hC0D6C0D7);
    wb_idle();
    @(negedge clk); wb_drive(32'h10C, 32'hAABB0000, 4'hC, 1'b1);
    @(negedge clk); #1;
    check("wt_adr", c_adr_o, 32'h10C);
    check("wt_dat", 32'(c_dat_o), 32'hAABB);
    @(negedge clk); c_ack = 1'b1;
    #1 check("wt_ackcyc_acc", 32'(c_acc), 32'h0);
    @(negedge clk); c_ack = 1'b0;
    #1 check("wt_wback", 32'(wb_ack), 32'h1);
    wb_idle();
    @(negedge clk); wb_drive(32'h10C, 32'h0, 4'hF, 1'b0);
    @(negedge clk); #1 check("rh2_wback", 32'(wb_ack), 32'h1);
    check("rh2_dat", wb_dat_r, 32'hAABBC0D7);
    wb_idle();
    check("rh_rd_count", 32'(n_rd - r0), 32'h0);

    // Reset in the middle of a fill, then refill with cyc dropped part way
    @(negedge clk); wb_drive(32'h300, 32'h0, 4'hF, 1'b0); r0 = n_rd;
    @(negedge clk); #1 check("rf_acc", 32'(c_acc), 32'h1);
    @(negedge clk); beat(32'h300, 16'h3000, 1'b1);
    @(negedge clk); beat(32'h302, 16'h3001, 1'b0);
    @(negedge clk); beat(32'h304, 16'h3002, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #1 check("rf_rst_acc", 32'(c_acc), 32'h0);
    check("rf_rst_ack", 32'(wb_ack), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("rf_re_acc", 32'(c_acc), 32'h1);
    check("rf_re_adr", c_adr_o, 32'h300);
    a0 = n_ack;
    @(negedge clk); beat(32'h300, 16'h3000, 1'b1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); beat(32'h300 + 32'(2 * k), 16'h3000 + 16'(k), 1'b0);
      if (k == 2) wb_idle();
    end
    repeat (4) @(negedge clk);
    #1 check("rf_nocyc_ack", 32'(n_ack - a0), 32'h0);
    check("rf_rd_count", 32'(n_rd - r0), 32'h2);
    wb_drive(32'h308, 32'h0, 4'hF, 1'b0); r0 = n_rd;
    @(negedge clk); #1 check("rf_hit_ack", 32'(wb_ack), 32'h1);
    check("rf_hit_dat", wb_dat_r, 32'h30043005);
    wb_idle();
    @(negedge clk); #1 check("rf_hit_rd_count", 32'(n_rd - r0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
